// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end of the emulated key matrix:
// receiver state encoding and the scan-code prefix / modifier constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] BREAK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX   = 8'hE0;
  localparam logic [7:0] LSHIFT    = 8'h12;
  localparam logic [7:0] RSHIFT    = 8'h59;
  localparam logic [7:0] CTRL      = 8'h14;

endpackage

// File: rtl/ps2_scancode_map.sv
// PS/2 set-2 scan code to emulated matrix index lookup (purely combinational).
module ps2_scancode_map
  import ps2_pkg::*;
#(
  parameter int SCAN_W = 4
) (
  input  logic [7:0]        code,
  output logic              hit,
  output logic [SCAN_W-1:0] idx
);

  int idx_n;

  always_comb begin
    hit   = 1'b1;
    idx_n = 0;
    case (code)
      8'h45:   idx_n = 0;
      8'h16:   idx_n = 1;
      8'h1E:   idx_n = 2;
      8'h26:   idx_n = 3;
      8'h25:   idx_n = 4;
      8'h2E:   idx_n = 5;
      8'h36:   idx_n = 6;
      8'h3D:   idx_n = 7;
      8'h3E:   idx_n = 8;
      8'h46:   idx_n = 9;
      8'h1C:   idx_n = 10;
      8'h1B:   idx_n = 11;
      8'h23:   idx_n = 12;
      8'h1D:   idx_n = 13;
      8'h5A:   idx_n = 14;
      8'h29:   idx_n = 15;
      default: hit   = 1'b0;
    endcase
    idx = SCAN_W'(idx_n);
  end

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 receiver feeding an n-key make/break table, answered as an active-low Atari key matrix.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not check.
module ps2_key_matrix
  import ps2_pkg::*;
#(
  parameter int SCAN_W      = 4,
  parameter int TIMEOUT_CYC = 2000,
  parameter int SHIFT_IDX   = 15,
  parameter int CTRL_IDX    = 14
) (
  input  logic              o2,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic [SCAN_W-1:0] key_scan_L,
  output logic              kr1_L,
  output logic              kr2_L,
  output logic              code_valid,
  output logic [7:0]        last_code,
  output logic              frame_err
);

  localparam int NKEYS = 2 ** SCAN_W;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  ps2_state_e       state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       sr_q, sr_d;
  logic             parity_q, parity_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       last_code_q, last_code_d;
  logic             code_valid_q, code_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [NKEYS-1:0] pressed_q, pressed_d;
  logic             shift_held_q, shift_held_d;
  logic             ctrl_held_q, ctrl_held_d;
  logic             break_pend_q, break_pend_d;
  logic             ext_pend_q, ext_pend_d;

  logic              fall, data_bit, parity_ok, accept, err;
  logic              map_hit;
  logic [SCAN_W-1:0] map_idx, scan_idx;

  // Bit 2 is the delayed copy of the synchronised clock, used only for edge detection.
  assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{sr_q, parity_q};
`else
  logic parity_unused;
  assign parity_ok     = 1'b1;
  assign parity_unused = parity_q;
`endif

  ps2_scancode_map #(.SCAN_W(SCAN_W)) u_map (
    .code (sr_q),
    .hit  (map_hit),
    .idx  (map_idx)
  );

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    parity_d = parity_q;
    to_cnt_d = to_cnt_q;
    accept   = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall && !data_bit) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: if (fall) begin
        sr_d     = {data_bit, sr_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        parity_d = data_bit;
        state_d  = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (data_bit && parity_ok) accept = 1'b1;
        else err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A falling edge in the same cycle as expiry keeps the frame alive.
    if (state_q != IDLE) begin
      if (fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_MAX) begin
        state_d  = IDLE;
        to_cnt_d = '0;
        err      = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    last_code_d  = last_code_q;
    code_valid_d = accept;
    frame_err_d  = err;
    pressed_d    = pressed_q;
    shift_held_d = shift_held_q;
    ctrl_held_d  = ctrl_held_q;
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    if (accept) begin
      last_code_d = sr_q;
      if (sr_q == BREAK_PFX) begin
        break_pend_d = 1'b1;
      end else if (sr_q == EXT_PFX) begin
        ext_pend_d = 1'b1;
      end else begin
        // Extended keys share codes with plain keys; drop them rather than alias.
        if (!ext_pend_q) begin
          if (map_hit) pressed_d[map_idx] = ~break_pend_q;
          if (sr_q == LSHIFT || sr_q == RSHIFT) shift_held_d = ~break_pend_q;
          if (sr_q == CTRL) ctrl_held_d = ~break_pend_q;
        end
        break_pend_d = 1'b0;
        ext_pend_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge o2) begin
    if (rst) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      sr_q         <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      last_code_q  <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      pressed_q    <= '0;
      shift_held_q <= 1'b0;
      ctrl_held_q  <= 1'b0;
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      sr_q         <= sr_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      last_code_q  <= last_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      pressed_q    <= pressed_d;
      shift_held_q <= shift_held_d;
      ctrl_held_q  <= ctrl_held_d;
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
    end
  end

  // Matrix reads are combinational so the scanner sees the current address on its own edge.
  assign scan_idx   = ~key_scan_L;
  assign kr1_L      = ~pressed_q[scan_idx];
  assign kr2_L      = ~((shift_held_q && (scan_idx == SCAN_W'(SHIFT_IDX))) ||
                        (ctrl_held_q  && (scan_idx == SCAN_W'(CTRL_IDX))));
  assign code_valid = code_valid_q;
  assign last_code  = last_code_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed plus randomized PS/2 frames checked against a key-table reference model.
module tb_ps2_key_matrix;

  localparam int SCAN_W      = 4;
  localparam int TIMEOUT_CYC = 2000;
  localparam int SHIFT_IDX   = 15;
  localparam int CTRL_IDX    = 14;
  localparam int NK          = 16;

  logic        o2 = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic [3:0]  key_scan_L;
  logic        kr1_L, kr2_L, code_valid, frame_err;
  logic [7:0]  last_code;

  ps2_key_matrix #(
    .SCAN_W(SCAN_W), .TIMEOUT_CYC(TIMEOUT_CYC), .SHIFT_IDX(SHIFT_IDX), .CTRL_IDX(CTRL_IDX)
  ) dut (
    .o2(o2), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .key_scan_L(key_scan_L),
    .kr1_L(kr1_L), .kr2_L(kr2_L), .code_valid(code_valid), .last_code(last_code),
    .frame_err(frame_err)
  );

  always #5 o2 = ~o2;

  int total = 0;
  int bad   = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int half  = 12;

  always @(negedge o2) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  // Reference model: key table keyed by the documented code list.
  logic [7:0] keymap [NK] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h5A, 8'h29};
  bit         m_pressed [NK];
  bit         m_shift, m_ctrl, m_brk, m_ext;
  logic [7:0] m_last;
  int         m_cv, m_fe;

  task automatic model_reset();
    for (int i = 0; i < NK; i++) m_pressed[i] = 1'b0;
    m_shift = 0; m_ctrl = 0; m_brk = 0; m_ext = 0; m_last = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_fe++;
    end else begin
      m_cv++;
      m_last = b;
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
        if (!m_ext) begin
          for (int i = 0; i < NK; i++) if (keymap[i] == b) m_pressed[i] = !m_brk;
          if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
          if (b == 8'h14) m_ctrl = !m_brk;
        end
        m_brk = 0;
        m_ext = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [3:0] iv;
    chk({tag, " code_valid count"}, cv_cnt, m_cv);
    chk({tag, " frame_err count"}, fe_cnt, m_fe);
    chk({tag, " last_code"}, {24'd0, last_code}, {24'd0, m_last});
    for (int i = 0; i < NK; i++) begin
      iv = 4'(i);
      key_scan_L = ~iv;
      #1;
      chk($sformatf("%s kr1_L[%0d]", tag, i), {31'd0, kr1_L}, {31'd0, !m_pressed[i]});
      chk($sformatf("%s kr2_L[%0d]", tag, i), {31'd0, kr2_L},
          {31'd0, !((m_shift && i == SHIFT_IDX) || (m_ctrl && i == CTRL_IDX))});
    end
    key_scan_L = 4'hF;
    @(negedge o2);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge o2);
      ps2_data = bits[i];
      repeat (half) @(negedge o2);
      ps2_clk = 1'b0;
      repeat (half) @(negedge o2);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par);
    logic par;
    bit   good;
    par  = (~^b) ^ bad_par;
    send_bits({stop, par, b, 1'b0}, 11);
    repeat (8) @(negedge o2);
    good = stop;
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) good = 0;
`endif
    model_frame(b, good);
    $display("frame code=%02h stop=%0d badpar=%0d half=%0d last_code=%02h", b, stop, bad_par, half, last_code);
  endtask

  initial begin
    int fe_before;
    int r;
    logic [7:0] code;
    bit stop;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; key_scan_L = 4'hF;
    m_cv = 0; m_fe = 0;
    model_reset();
    repeat (4) @(negedge o2);
    chk("reset code_valid", {31'd0, code_valid}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    check_state("reset");
    rst = 1'b0;
    repeat (4) @(negedge o2);

    send_frame(8'h16, 1, 0);           check_state("make16");
    send_frame(8'hF0, 1, 0);
    send_frame(8'h16, 1, 0);           check_state("break16");
    send_frame(8'h12, 1, 0);           check_state("shift_make");
    send_frame(8'hF0, 1, 0);
    send_frame(8'h12, 1, 0);           check_state("shift_break");
    send_frame(8'h14, 1, 0);           check_state("ctrl_make");
    send_frame(8'h1C, 0, 0);           check_state("bad_stop");
    send_frame(8'h1C, 1, 1);           check_state("bad_parity");

    // Abort a frame part-way and let the receiver time out.
    send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 5);
    fe_before = fe_cnt;
    for (int c = 0; c < TIMEOUT_CYC + 50; c++) begin
      @(negedge o2);
      if (fe_cnt != fe_before) break;
    end
    repeat (2) @(negedge o2);
    m_fe++;
    $display("timeout frame_err count=%0d", fe_cnt);
    check_state("timeout");
    send_frame(8'h29, 1, 0);           check_state("after_timeout");

    send_frame(8'h45, 1, 0);
    send_frame(8'h1E, 1, 0);           check_state("rollover");
    send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 6);
    @(negedge o2);
    rst = 1'b1;
    repeat (3) @(negedge o2);
    rst = 1'b0;
    cv_cnt = 0; fe_cnt = 0; m_cv = 0; m_fe = 0;
    model_reset();
    repeat (20) @(negedge o2);
    $display("mid-frame reset released");
    check_state("mid_reset");
    send_frame(8'hE0, 1, 0);
    send_frame(8'h5A, 1, 0);           check_state("ext_ignored");
    send_frame(8'h45, 1, 0);           check_state("pend_cleared");

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 9: code = keymap[$urandom_range(0, NK - 1)];
        4:             code = 8'hF0;
        5:             code = 8'hE0;
        6:             code = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        7:             code = 8'h14;
        default:       code = 8'($urandom());
      endcase
      stop = ($urandom_range(0, 7) != 0);
      half = int'($urandom_range(6, 20));
      send_frame(code, stop, 0);
      check_state($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
